// File: rtl/seg7_digit_sequencer.sv
// Shows an 8-bit unsigned value on one seven-segment digit, most significant
// non-zero decimal digit first. Binary-to-BCD conversion is done serially with
// double-dabble, then each digit is shown for DIGIT_TICKS cycles with blank
// gaps between digits and a longer blank pause after the ones digit.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | display blank, waiting for load
//   CONVERT | 8 double-dabble shift cycles, display blank, load ignored
//   SHOW    | current BCD nibble on the display for DIGIT_TICKS cycles
//   GAP     | blank for GAP_TICKS cycles between digits
//   PAUSE   | blank for 4*GAP_TICKS cycles after the ones digit; done on last
module seg7_digit_sequencer #(
   parameter int DIGIT_TICKS = 1000,
   parameter int GAP_TICKS   = 250,
   parameter bit REPEAT      = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] value,
   input  logic       load,
   output logic [3:0] digit,
   output logic [1:0] digit_pos,
   output logic       busy,
   output logic       done
);

   localparam int PAUSE_TICKS = 4 * GAP_TICKS;
   localparam int MAX_TICKS   = (DIGIT_TICKS > PAUSE_TICKS) ? DIGIT_TICKS : PAUSE_TICKS;
   localparam int TW          = $clog2(MAX_TICKS) + 1;

   localparam logic [TW-1:0] DIGIT_LAST = TW'(DIGIT_TICKS - 1);
   localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
   localparam logic [TW-1:0] PAUSE_LAST = TW'(PAUSE_TICKS - 1);
   localparam logic [TW-1:0] TICK_ONE   = TW'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CONVERT = 3'd1,
      S_SHOW    = 3'd2,
      S_GAP     = 3'd3,
      S_PAUSE   = 3'd4
   } state_t;

   state_t          state, state_nxt;
   logic [7:0]      bin, bin_nxt;
   logic [11:0]     bcd, bcd_nxt, bcd_adj;
   logic [2:0]      iter, iter_nxt;
   logic [TW-1:0]   tick, tick_nxt;
   logic [1:0]      pos, pos_nxt;
   logic            load_ok;

   logic [3:0]      digit_nxt;
   logic [1:0]      digit_pos_nxt;
   logic            busy_nxt;
   logic            done_nxt;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? (n + 4'd3) : n;
   endfunction

   // Place of the most significant non-zero digit; a zero value shows the ones place.
   function automatic logic [1:0] first_place(input logic [11:0] b);
      logic [1:0] p;
      if (b[11:8] != 4'd0)
         p = 2'd2;
      else if (b[7:4] != 4'd0)
         p = 2'd1;
      else
         p = 2'd0;
      return p;
   endfunction

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         bin   <= 8'd0;
         bcd   <= 12'd0;
         iter  <= 3'd0;
         tick  <= '0;
         pos   <= 2'd0;
      end else begin
         state <= state_nxt;
         bin   <= bin_nxt;
         bcd   <= bcd_nxt;
         iter  <= iter_nxt;
         tick  <= tick_nxt;
         pos   <= pos_nxt;
      end
   end

   // Next-state, conversion step and phase timing; an accepted load overrides all.
   always_comb begin
      state_nxt = state;
      bin_nxt   = bin;
      bcd_nxt   = bcd;
      iter_nxt  = iter;
      tick_nxt  = tick + TICK_ONE;
      pos_nxt   = pos;
      bcd_adj   = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
      load_ok   = load && (state != S_CONVERT);

      case (state)
         S_IDLE: begin
            tick_nxt = '0;
         end
         S_CONVERT: begin
            tick_nxt = '0;
            bcd_nxt  = {bcd_adj[10:0], bin[7]};
            bin_nxt  = {bin[6:0], 1'b0};
            iter_nxt = iter + 3'd1;
            if (iter == 3'd7) begin
               state_nxt = S_SHOW;
               pos_nxt   = first_place({bcd_adj[10:0], bin[7]});
            end
         end
         S_SHOW: begin
            if (tick == DIGIT_LAST) begin
               tick_nxt  = '0;
               state_nxt = (pos == 2'd0) ? S_PAUSE : S_GAP;
            end
         end
         S_GAP: begin
            if (tick == GAP_LAST) begin
               tick_nxt  = '0;
               state_nxt = S_SHOW;
               pos_nxt   = pos - 2'd1;
            end
         end
         S_PAUSE: begin
            if (tick == PAUSE_LAST) begin
               tick_nxt = '0;
               if (REPEAT) begin
                  state_nxt = S_SHOW;
                  pos_nxt   = first_place(bcd);
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
            tick_nxt  = '0;
         end
      endcase

      if (load_ok) begin
         state_nxt = S_CONVERT;
         bin_nxt   = value;
         bcd_nxt   = 12'd0;
         iter_nxt  = 3'd0;
         tick_nxt  = '0;
         pos_nxt   = 2'd0;
      end
   end

   // Output values for the coming cycle, derived from where the FSM is going.
   always_comb begin
      digit_nxt     = 4'hF;
      digit_pos_nxt = 2'd0;
      busy_nxt      = (state_nxt != S_IDLE);
      done_nxt      = (state_nxt == S_PAUSE) && (tick_nxt == PAUSE_LAST);
      if (state_nxt == S_SHOW) begin
         digit_pos_nxt = pos_nxt;
         case (pos_nxt)
            2'd2:    digit_nxt = bcd_nxt[11:8];
            2'd1:    digit_nxt = bcd_nxt[7:4];
            default: digit_nxt = bcd_nxt[3:0];
         endcase
      end
   end

   // Registered outputs so the decoder never sees combinational glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit     <= 4'hF;
         digit_pos <= 2'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         digit     <= digit_nxt;
         digit_pos <= digit_pos_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: doc/seg7_digit_sequencer.md
Name: seg7_digit_sequencer

Overview:
- Presents an 8-bit unsigned result, such as a factor, on a single seven-segment digit, one decimal digit at a time.
- Converts binary to BCD serially using double-dabble, one shift per cycle.
- Suppresses leading zeros, then steps through the digits with timed on and blank phases.
- Drives the 4-bit digit input of the seven-segment decoder. Code 4'hF blanks the display, because the decoder maps non-decimal codes to all-segments-off.

Parameters:
- DIGIT_TICKS, 1000: clock cycles each digit is shown; must be >= 1.
- GAP_TICKS, 250: blank cycles between digits; must be >= 1. The end-of-number pause is 4*GAP_TICKS.
- REPEAT, 1: 1 = loop the number until a new load; 0 = show once, then go idle.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- value  input  8  unsigned number to display; sampled only on an accepted load
- load  input  1  start request; level-sampled each rising edge
- digit  output  4  BCD digit to the decoder; 4'hF = blank
- digit_pos  output  2  place of the shown digit: 2 = hundreds, 1 = tens, 0 = ones; 0 when blank
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse at the end of each full pass of the number

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE
  - digit = 4'hF, digit_pos = 0, busy = 0, done = 0
  - all counters and the shift register = 0
- Reset mid-operation aborts immediately to these values; no partial digit is held.
- States: IDLE, CONVERT, SHOW, GAP, PAUSE.
- Load acceptance:
  - Accepted in IDLE, SHOW, GAP and PAUSE.
  - Ignored in CONVERT.
  - An accepted load latches value, clears the 12-bit BCD accumulator, sets the iteration count to 0 and enters CONVERT.
  - In SHOW, GAP or PAUSE an accepted load aborts the current pass. No done pulse is issued for the aborted pass.
- CONVERT:
  - Runs exactly 8 cycles. On each edge, every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1.
  - On the 8th edge after the accepting edge, the next state is SHOW.
  - First digit is the most significant non-zero nibble. Value 0 shows the single digit 0 at pos 0.
- SHOW: digit = current nibble, digit_pos = its place, held for exactly DIGIT_TICKS cycles.
  - If more digits remain: go to GAP.
  - If this was the ones digit: go to PAUSE.
- GAP: digit = 4'hF for GAP_TICKS cycles, then SHOW the next lower place. Internal zeros are shown, e.g. 105 shows 1, 0, 5.
- PAUSE: digit = 4'hF for 4*GAP_TICKS cycles. On the final cycle, done = 1 for one cycle, then:
  - REPEAT = 1: go to SHOW of the first digit. No reconversion; the BCD value is retained.
  - REPEAT = 0: go to IDLE.
- Load coinciding with the done cycle: the load wins. done is still asserted that cycle, and the next state is CONVERT.
- Tick counter:
  - Width is clog2(max(DIGIT_TICKS, 4*GAP_TICKS)) + 1.
  - Resets to 0 on every state entry and never wraps within a phase.
- Outputs are registered; digit changes only on state transitions.

Test Plan:
All scenarios use DIGIT_TICKS = 4 and GAP_TICKS = 2.
1. REPEAT=0, load value=123 -> busy rises on the next edge. Output sequence:
   - 8 cycles of 4'hF
   - 1 (pos 2) x4 cycles, F x2
   - 2 (pos 1) x4 cycles, F x2
   - 3 (pos 0) x4 cycles, F x8
   - done for 1 cycle on the last F cycle, then busy = 0
2. value=0 -> only digit 0 at pos 0 for 4 cycles. value=7 -> only 7 at pos 0. value=105 -> 1, 0, 5. value=255 -> 2, 5, 5.
3. REPEAT=1, value=40 -> 4, F x2, 0, F x8 with done, then 4 again at pos 1, repeating indefinitely with busy held high.
4. Load value=99 during CONVERT of 200 -> ignored; 2, 0, 0 is displayed. Load value=9 during SHOW of digit 2 -> digit = F within 1 cycle, no done pulse, then 9 after 8 cycles.
5. rst_n low during GAP -> digit = F, busy = 0 and done = 0 asynchronously. After release with no load, the block stays IDLE.
6. Load asserted in the same cycle as done with REPEAT=1 -> done is seen, the next state is CONVERT, and the new value is displayed.
